pipe_mult_stream: RTL and testbench

- Parametrised, fully pipelined N-bit multiplier; the successor to the single-cycle fixed-width 5-bit shift-and-add multiplier.
- Accepts one operand pair per clock through a valid/ready handshake and produces the exact 2N-bit product after a fixed latency.
- Supports a per-transaction signed or unsigned mode and passes a user tag through alongside the data.
- Intended as the multiply core of each systolic-array processing element; the tag carries the row/column index.

---
 rtl/mult_pkg.sv | 33 +++
 rtl/mult_tree_level.sv | 44 ++++
 rtl/pipe_mult_stream.sv | 93 +++++++++
 tb/tb_pipe_mult_stream.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and elaboration helpers for the pipelined multiplier
package mult_pkg;

   localparam int MAX_N = 32;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int mult_lat(input int n);
      return 1 + clog2(n);
   endfunction

   // Operand count entering adder-tree level k (level 0 = partial products).
   function automatic int lvl_cnt(input int n, input int k);
      int c;
      c = n;
      for (int i = 0; i < k; i++) c = (c + 1) / 2;
      return c;
   endfunction

   // Operand offset of level k inside the flat tree bus.
   function automatic int lvl_off(input int n, input int k);
      int s;
      s = 0;
      for (int i = 0; i < k; i++) s += lvl_cnt(n, i);
      return s;
   endfunction

endpackage

// File: rtl/mult_tree_level.sv
// rtl/mult_tree_level.sv - one registered adder-tree level, pairs summed, odd last operand passed
module mult_tree_level
   import mult_pkg::*;
#(
   parameter int IN_CNT = 8,
   parameter int W      = 16,
   parameter int TAG_W  = 4
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              in_valid,
   input  logic [TAG_W-1:0]                  in_tag,
   input  logic [IN_CNT*W-1:0]               in_data,
   output logic                              out_valid,
   output logic [TAG_W-1:0]                  out_tag,
   output logic [((IN_CNT+1)/2)*W-1:0]       out_data
);

   localparam int OUT_CNT = (IN_CNT + 1) / 2;

   logic [OUT_CNT*W-1:0] sum;

   for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
      if (2*j + 1 < IN_CNT) begin : g_add
         assign sum[j*W +: W] = in_data[(2*j)*W +: W] + in_data[(2*j+1)*W +: W];
      end else begin : g_pass
         assign sum[j*W +: W] = in_data[(2*j)*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_tag   <= in_tag;
         out_data  <= sum;
      end
   end

endmodule

// File: rtl/pipe_mult_stream.sv
// rtl/pipe_mult_stream.sv - fully pipelined signed/unsigned N-bit multiplier with valid/ready and tag
module pipe_mult_stream
   import mult_pkg::*;
#(
   parameter int N     = 8,
   parameter int TAG_W = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_a,
   input  logic [N-1:0]       in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*N-1:0]     out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int LEVELS = clog2(N);
   localparam int PW     = 2 * N;
   localparam int TOT    = lvl_off(N, LEVELS + 1);

   // Every tree level lives in one flat bus so each slice has exactly one driver.
   wire [TOT*PW-1:0]             tree;
   wire [LEVELS:0]               v;
   wire [LEVELS:0][TAG_W-1:0]    tag;

   logic [N*PW-1:0]  pp_d;
   logic [N*PW-1:0]  pp_q;
   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    term;
   logic             v0_q;
   logic [TAG_W-1:0] tag0_q;
   logic             en;

   assign en       = !out_valid | out_ready;
   assign in_ready = en & !rst;

   // In signed mode the multiplier MSB carries weight -2^(N-1), so that row is negated.
   always_comb begin
      pp_d  = '0;
      term  = '0;
      a_ext = in_signed ? {{N{in_a[N-1]}}, in_a} : {{N{1'b0}}, in_a};
      for (int i = 0; i < N; i++) begin
         term = in_b[i] ? (a_ext << i) : '0;
         if (in_signed && (i == N - 1)) term = -term;
         pp_d[i*PW +: PW] = term;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pp_q   <= '0;
         v0_q   <= 1'b0;
         tag0_q <= '0;
      end else if (en) begin
         pp_q   <= pp_d;
         v0_q   <= in_valid & in_ready;
         tag0_q <= in_tag;
      end
   end

   assign tree[0 +: N*PW] = pp_q;
   assign v[0]            = v0_q;
   assign tag[0]          = tag0_q;

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      mult_tree_level #(
         .IN_CNT (lvl_cnt(N, k)),
         .W      (PW),
         .TAG_W  (TAG_W)
      ) u_lvl (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .in_valid  (v[k]),
         .in_tag    (tag[k]),
         .in_data   (tree[lvl_off(N, k)*PW +: lvl_cnt(N, k)*PW]),
         .out_valid (v[k+1]),
         .out_tag   (tag[k+1]),
         .out_data  (tree[lvl_off(N, k+1)*PW +: lvl_cnt(N, k+1)*PW])
      );
   end

   // Bubble slots carry whatever data was loaded; only valid results leave the block.
   assign out_valid = v[LEVELS];
   assign out_p     = out_valid ? tree[lvl_off(N, LEVELS)*PW +: PW] : '0;
   assign out_tag   = out_valid ? tag[LEVELS] : '0;

endmodule

// File: tb/tb_pipe_mult_stream.sv
// tb/tb_pipe_mult_stream.sv - directed and random self-checking bench for pipe_mult_stream
module tb_pipe_mult_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [7:0]  in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [15:0] out_p;

   logic        in_valid5, in_ready5, in_signed5, out_valid5, out_ready5;
   logic [4:0]  in_a5, in_b5;
   logic [3:0]  in_tag5, out_tag5;
   logic [9:0]  out_p5;

   logic        in_valid13, in_ready13, in_signed13, out_valid13, out_ready13;
   logic [12:0] in_a13, in_b13;
   logic [3:0]  in_tag13, out_tag13;
   logic [25:0] out_p13;

   int errors = 0;
   int checks = 0;

   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   logic        qs[$];
   logic [3:0]  qt[$];
   logic [15:0] rp[$];
   logic [3:0]  rt[$];
   int          rc[$];
   int          tc[$];

   pipe_mult_stream #(.N(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .out_tag(out_tag));

   pipe_mult_stream #(.N(5), .TAG_W(4)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_a(in_a5), .in_b(in_b5),
      .in_signed(in_signed5), .in_tag(in_tag5), .out_valid(out_valid5), .out_ready(out_ready5),
      .out_p(out_p5), .out_tag(out_tag5));

   pipe_mult_stream #(.N(13), .TAG_W(4)) dut13 (
      .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13), .in_a(in_a13), .in_b(in_b13),
      .in_signed(in_signed13), .in_tag(in_tag13), .out_valid(out_valid13), .out_ready(out_ready13),
      .out_p(out_p13), .out_tag(out_tag13));

   function automatic longint refp(input longint a, input longint b, input bit s, input int n);
      longint x, y, p;
      x = a;
      y = b;
      if (s && x[n-1]) x = x - (longint'(1) << n);
      if (s && y[n-1]) y = y - (longint'(1) << n);
      p = x * y;
      return p & ((longint'(1) << (2 * n)) - 1);
   endfunction

   task automatic clear_q();
      qa.delete(); qb.delete(); qs.delete(); qt.delete();
      rp.delete(); rt.delete(); rc.delete(); tc.delete();
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
      qa.push_back(a); qb.push_back(b); qs.push_back(s); qt.push_back(t);
   endtask

   // Streams the queued operands into dut8 with out_ready held high, recording results and cycles.
   task automatic drive8(input int max_cyc);
      int idx, cyc;
      idx = 0;
      cyc = 0;
      while ((rp.size() < qa.size()) && (cyc < max_cyc)) begin
         out_ready = 1'b1;
         if (idx < qa.size()) begin
            in_valid = 1'b1; in_a = qa[idx]; in_b = qb[idx]; in_signed = qs[idx]; in_tag = qt[idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin tc.push_back(cyc); idx++; end
         if (out_valid && out_ready) begin rp.push_back(out_p); rt.push_back(out_tag); rc.push_back(cyc); end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_signed = 1'b1; in_tag = 4'hF; out_ready = 1'b1;
      in_valid5 = 1'b0; in_a5 = '0; in_b5 = '0; in_signed5 = 1'b0; in_tag5 = '0; out_ready5 = 1'b1;
      in_valid13 = 1'b0; in_a13 = '0; in_b13 = '0; in_signed13 = 1'b0; in_tag13 = '0; out_ready13 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (out_p !== 16'h0) begin errors++; $display("FAIL reset_out_p got=%h want=0000", out_p); end
      checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      clear_q();
      push(8'hFF, 8'hFF, 1'b0, 4'd3);
      drive8(40);
      checks++;
      if (rp.size() != 1) begin errors++; $display("FAIL latency_count got=%0d want=1", rp.size()); end
      else begin
         checks++; if (rp[0] !== 16'hFE01) begin errors++; $display("FAIL latency_p got=%h want=fe01", rp[0]); end
         checks++; if (rt[0] !== 4'd3) begin errors++; $display("FAIL latency_tag got=%h want=3", rt[0]); end
         checks++; if (rc[0] - tc[0] !== 4) begin errors++; $display("FAIL latency_cycles got=%0d want=4", rc[0] - tc[0]); end
      end
   endtask

   task automatic test_signed_b2b();
      logic [15:0] ep [4];
      ep = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0000};
      clear_q();
      push(8'h80, 8'h80, 1'b1, 4'd1);
      push(8'hFF, 8'h01, 1'b1, 4'd2);
      push(8'h7F, 8'h80, 1'b1, 4'd3);
      push(8'h00, 8'hFB, 1'b1, 4'd4);
      drive8(40);
      checks++;
      if (rp.size() != 4) begin errors++; $display("FAIL signed_count got=%0d want=4", rp.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rp[i] !== ep[i] || rt[i] !== 4'(i + 1)) begin
               errors++; $display("FAIL signed_result[%0d] got p=%h tag=%h want p=%h tag=%h", i, rp[i], rt[i], ep[i], 4'(i + 1));
            end
            checks++;
            if (rc[i] !== rc[0] + i) begin
               errors++; $display("FAIL signed_consecutive[%0d] got cycle=%0d want=%0d", i, rc[i], rc[0] + i);
            end
         end
      end
   endtask

   task automatic test_mixed_mode();
      logic [15:0] e;
      clear_q();
      for (int i = 0; i < 20; i++) push(8'hFF, 8'hFF, 1'(i % 2), 4'(i));
      drive8(80);
      checks++;
      if (rp.size() != 20) begin errors++; $display("FAIL mixed_count got=%0d want=20", rp.size()); end
      else begin
         for (int i = 0; i < 20; i++) begin
            e = (i % 2 == 1) ? 16'h0001 : 16'hFE01;
            checks++;
            if (rp[i] !== e || rt[i] !== 4'(i) || rc[i] !== rc[0] + i) begin
               errors++; $display("FAIL mixed_result[%0d] got p=%h tag=%h cyc=%0d want p=%h tag=%h cyc=%0d", i, rp[i], rt[i], rc[i], e, 4'(i), rc[0] + i);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] ep [6];
      logic [15:0] held_p;
      logic [3:0]  held_t;
      int idx, cyc, stall_left;
      bit stalled;
      ep = '{16'h00C8, 16'h00E7, 16'h0108, 16'h012B, 16'h0150, 16'h0177};
      clear_q();
      for (int i = 0; i < 6; i++) push(8'(i + 10), 8'(i + 20), 1'b0, 4'(i + 8));
      idx = 0; cyc = 0; stall_left = 0; stalled = 0; held_p = '0; held_t = '0;
      while ((rp.size() < 6) && (cyc < 60)) begin
         if (!stalled && out_valid) begin
            stalled = 1; stall_left = 3; held_p = out_p; held_t = out_tag;
         end
         out_ready = (stall_left == 0);
         if (idx < 6) begin
            in_valid = 1'b1; in_a = qa[idx]; in_b = qb[idx]; in_signed = qs[idx]; in_tag = qt[idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stall_left > 0) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
            if (stall_left < 3) begin
               checks++;
               if (out_valid !== 1'b1 || out_p !== held_p || out_tag !== held_t) begin
                  errors++; $display("FAIL stall_hold got v=%b p=%h tag=%h want v=1 p=%h tag=%h", out_valid, out_p, out_tag, held_p, held_t);
               end
            end
            stall_left--;
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin rp.push_back(out_p); rt.push_back(out_tag); end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_occurred got=%b want=1", stalled); end
      checks++; if (held_p !== 16'h00C8) begin errors++; $display("FAIL stall_first_p got=%h want=00c8", held_p); end
      checks++;
      if (rp.size() != 6) begin errors++; $display("FAIL stall_count got=%0d want=6", rp.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (rp[i] !== ep[i] || rt[i] !== 4'(i + 8)) begin
               errors++; $display("FAIL stall_result[%0d] got p=%h tag=%h want p=%h tag=%h", i, rp[i], rt[i], ep[i], 4'(i + 8));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 8'(i + 1); in_b = 8'd9; in_signed = 1'b0; in_tag = 4'(i + 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
      checks++; if (out_p !== 16'h0) begin errors++; $display("FAIL midrst_out_p got=%h want=0000", out_p); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_during got=%b want=0", in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready_after got=%b want=1", in_ready); end
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_ghost_results got=%0d want=0", seen); end
   endtask

   task automatic test_sweep5();
      longint ep[$];
      logic [3:0] et[$];
      longint e;
      logic [3:0] t;
      int sent, got, cyc, lat;
      bit acc;
      out_ready5 = 1'b1;
      in_valid5 = 1'b1; in_a5 = 5'd3; in_b5 = 5'd7; in_signed5 = 1'b0; in_tag5 = 4'd5;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      lat = 1;
      while (!out_valid5 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 4 || out_p5 !== 10'd21 || out_tag5 !== 4'd5) begin
         errors++; $display("FAIL sweep5_latency got lat=%0d p=%h tag=%h want lat=4 p=015 tag=5", lat, out_p5, out_tag5);
      end
      @(posedge clk); #1;
      sent = 0; got = 0; cyc = 0;
      while (got < 10000 && cyc < 40000) begin
         out_ready5 = ($urandom_range(0, 3) != 0);
         if (!in_valid5 && sent < 10000 && $urandom_range(0, 4) != 0) begin
            in_valid5 = 1'b1; in_a5 = 5'($urandom); in_b5 = 5'($urandom);
            in_signed5 = 1'($urandom); in_tag5 = 4'($urandom);
         end
         #1;
         acc = 0;
         if (in_valid5 && in_ready5) begin
            ep.push_back(refp(longint'(in_a5), longint'(in_b5), in_signed5, 5));
            et.push_back(in_tag5);
            sent++; acc = 1;
         end
         checks++;
         if (!out_valid5 && out_p5 !== '0) begin errors++; $display("FAIL sweep5_idle_p got=%h want=000", out_p5); end
         if (out_valid5 && out_ready5) begin
            e = (ep.size() > 0) ? ep.pop_front() : -1;
            t = (et.size() > 0) ? et.pop_front() : 4'hx;
            checks++;
            if (longint'(out_p5) !== e || out_tag5 !== t) begin
               errors++; $display("FAIL sweep5_result[%0d] got p=%h tag=%h want p=%h tag=%h", got, out_p5, out_tag5, e, t);
            end
            got++;
         end
         @(posedge clk); #1;
         if (acc) in_valid5 = 1'b0;
         cyc++;
      end
      in_valid5 = 1'b0;
      checks++; if (got !== 10000) begin errors++; $display("FAIL sweep5_count got=%0d want=10000", got); end
   endtask

   task automatic test_sweep13();
      longint ep[$];
      logic [3:0] et[$];
      longint e;
      logic [3:0] t;
      int sent, got, cyc, lat;
      bit acc;
      out_ready13 = 1'b1;
      in_valid13 = 1'b1; in_a13 = 13'h1FFF; in_b13 = 13'd2; in_signed13 = 1'b1; in_tag13 = 4'd9;
      @(posedge clk); #1;
      in_valid13 = 1'b0;
      lat = 1;
      while (!out_valid13 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 5 || out_p13 !== 26'h3FFFFFE || out_tag13 !== 4'd9) begin
         errors++; $display("FAIL sweep13_latency got lat=%0d p=%h tag=%h want lat=5 p=3fffffe tag=9", lat, out_p13, out_tag13);
      end
      @(posedge clk); #1;
      sent = 0; got = 0; cyc = 0;
      while (got < 10000 && cyc < 40000) begin
         out_ready13 = ($urandom_range(0, 3) != 0);
         if (!in_valid13 && sent < 10000 && $urandom_range(0, 4) != 0) begin
            in_valid13 = 1'b1; in_a13 = 13'($urandom); in_b13 = 13'($urandom);
            in_signed13 = 1'($urandom); in_tag13 = 4'($urandom);
         end
         #1;
         acc = 0;
         if (in_valid13 && in_ready13) begin
            ep.push_back(refp(longint'(in_a13), longint'(in_b13), in_signed13, 13));
            et.push_back(in_tag13);
            sent++; acc = 1;
         end
         checks++;
         if (!out_valid13 && out_p13 !== '0) begin errors++; $display("FAIL sweep13_idle_p got=%h want=0", out_p13); end
         if (out_valid13 && out_ready13) begin
            e = (ep.size() > 0) ? ep.pop_front() : -1;
            t = (et.size() > 0) ? et.pop_front() : 4'hx;
            checks++;
            if (longint'(out_p13) !== e || out_tag13 !== t) begin
               errors++; $display("FAIL sweep13_result[%0d] got p=%h tag=%h want p=%h tag=%h", got, out_p13, out_tag13, e, t);
            end
            got++;
         end
         @(posedge clk); #1;
         if (acc) in_valid13 = 1'b0;
         cyc++;
      end
      in_valid13 = 1'b0;
      checks++; if (got !== 10000) begin errors++; $display("FAIL sweep13_count got=%0d want=10000", got); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_signed_b2b();
      test_mixed_mode();
      test_stall();
      test_reset_mid();
      test_sweep5();
      test_sweep13();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
